// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader state encoding, halt word and default widths
package loader_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    // Also used by the CPU's halt detection, so keep it here rather than in the loader.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        RUN,
        ERR
    } state_t;
endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - instruction word stream in, instruction RAM write port out
interface program_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - wrapping sum of loaded words with clear/add and compare
module loader_checksum
    import loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    output logic              match
);
    logic [DATA_W-1:0] sum;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign match = (sum == data);
endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader writing a word stream into instruction RAM; LOADER_CHECKSUM_EN adds a trailing checksum check
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   start,
    program_loader_if.slave        bus,
    output logic                   cpu_run,
    output logic                   done,
    output logic                   error
);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              armed;
    logic              start_ok;
    logic              xfer;
    logic              is_halt;

    // armed stays low for the first edge after reset release so a start held
    // across the release is not taken.
    assign start_ok = start && armed && (state == IDLE);
    assign xfer     = bus.in_valid && bus.in_ready;
    assign is_halt  = (bus.in_data == DATA_W'(HALT_WORD));

    assign bus.in_ready = (state == LOAD) || (state == CHECK);
    assign cpu_run      = (state == RUN);
    assign done         = (state == RUN);
    assign error        = (state == ERR);

`ifdef LOADER_CHECKSUM_EN
    logic sum_match;

    loader_checksum #(.DATA_W(DATA_W)) u_checksum (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clear (start_ok),
        .add   (xfer && (state == LOAD)),
        .data  (bus.in_data),
        .match (sum_match)
    );
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nx = LOAD;
            end
            LOAD: begin
                if (bus.in_valid) begin
                    if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nx = CHECK;
`else
                        state_nx = RUN;
`endif
                    end else if (ptr == PTR_MAX) begin
                        state_nx = ERR;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (bus.in_valid) state_nx = sum_match ? RUN : ERR;
            end
`endif
            default: ;
        endcase
    end

    // RAM write port is registered; the pointer saturates instead of wrapping.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ptr           <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start_ok) begin
                ptr <= '0;
            end else if (xfer && (state == LOAD)) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= ptr;
                bus.mem_wdata <= bus.in_data;
                if (ptr != PTR_MAX) ptr <= ptr + 1'b1;
            end
        end
    end
endmodule
